elevator_scheduler: RTL and testbench
=====================================

# elevator_scheduler

Collective up/down scheduler that sits above `buttons_res` and drives the car. It reads the latched cabin and hall calls, moves the car one floor at a time, and opens the door at each served floor. It returns one-cycle `inactivate_*` pulses so `buttons_res` clears the served calls.

## Interface
- `FLOORS`, 8: number of floors, ≥ 2; floor index FW = $clog2(FLOORS) bits.
- `TRAVEL_CYCLES`, 100: clock cycles per one-floor move, ≥ 1.
- `DOOR_CYCLES`, 50: clock cycles the door stays open, ≥ 3.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `active_in_levels`  in  [FLOORS-1:0]  latched cabin calls.
- `active_out_up_levels`  in  [FLOORS-2:0]  latched hall up calls.
- `active_out_down_levels`  in  [FLOORS-1:1]  latched hall down calls.
- `inactivate_in_levels`  out  [FLOORS-1:0]  one-cycle clear pulses.
- `inactivate_out_up_levels`  out  [FLOORS-2:0]  one-cycle clear pulses.
- `inactivate_out_down_levels`  out  [FLOORS-1:1]  one-cycle clear pulses.
- `current_floor`  out  FW  floor the car is at or last passed.
- `motor_up`, `motor_down`  out  1 each  travel command; never both high.
- `door_open`  out  1  door command.
- `dir_up`  out  1  travel preference: 1 = up, 0 = down.

## Operation
Derived terms, all combinational from the inputs and `current_floor` (cur):
- above: any cabin call, up call or down call at a floor > cur.
- below: any cabin call, up call or down call at a floor < cur.
- here: `active_in[cur]` | `up[cur]` | `down[cur]`.

States:
- **IDLE**
  - If here: go to DOOR.
  - Else if `dir_up` & above: set `dir_up` = 1, go to MOVE.
  - Else if below: set `dir_up` = 0, go to MOVE.
  - Else if above: set `dir_up` = 1, go to MOVE.
  - Else stay in IDLE.
- **MOVE**
  - Drive `motor_up` = `dir_up`, `motor_down` = !`dir_up`.
  - Travel counter counts 0 to TRAVEL_CYCLES-1.
  - At terminal count: cur ±1, counter cleared, go to CHECK.
- **CHECK** (one cycle, motor off)
  - Going up: stop if `in[cur]` | `up[cur]` | (`down[cur]` & !above).
  - Going down: stop if `in[cur]` | `down[cur]` | (`up[cur]` & !below).
  - If stopping: go to DOOR. Otherwise go to MOVE in the same direction.
  - At floor 0 or FLOORS-1 the car never continues past the end: it stops if here, else goes to IDLE.
- **DOOR entry**, the cycle the state becomes DOOR:
  - Compute the new direction, nd:
    - If `dir_up`: nd = up if above; else down if (below | `down[cur]`); else unchanged.
    - Symmetric when going down.
  - `dir_up` takes nd.
  - Pulse `inactivate_in[cur]`.
  - Pulse the hall call in direction nd at cur.
  - If neither above nor below, pulse both hall calls at cur.
  - Pulses are masked to bits that exist: no up bit at the top floor, no down bit at floor 0.
- **DOOR**
  - `door_open` = 1 while the door counter runs 0 to DOOR_CYCLES-1.
  - Reopen: from door-counter value 2 onward, if `in[cur]` or the hall call matching `dir_up` is active, pulse its inactivate bit and reload the counter to 0. Counter values 0–1 are masked to cover the `buttons_res` clear latency.
  - When the counter ends: go to IDLE.
- Reset, including mid-move or mid-door:
  - State IDLE, `current_floor` = 0, `dir_up` = 1, counters = 0.
  - All outputs 0, except `dir_up` = 1.

## Timing
- All outputs are registered.
- Inactivate pulses are exactly one cycle wide, asserted in the first DOOR cycle, or in the cycle after a reopen detect.
- Latency from IDLE with a call at a different floor: MOVE starts 1 cycle after the call is seen.
- Arrival: cur updates on the edge ending the TRAVEL_CYCLES-th MOVE cycle. CHECK lasts 1 cycle; DOOR begins on the next edge.
- Per-floor pass-through cost: TRAVEL_CYCLES + 1 cycles.
- Door hold: DOOR_CYCLES cycles, then 1 IDLE cycle before the next MOVE.
- Calls arriving during MOVE are considered at the next CHECK.
- A call at cur arriving during MOVE is not served until the car returns.
- Simultaneous calls above and below while idle: the current `dir_up` preference wins.

## Test plan
Bench parameters: FLOORS = 8, TRAVEL_CYCLES = 4, DOOR_CYCLES = 3.

- **Reset**
  - Stimulus: assert `reset` during MOVE.
  - Required: next cycle `current_floor` = 0, motors 0, `door_open` = 0, `dir_up` = 1, state IDLE.
- **Single cabin call**
  - Stimulus: `active_in[3]` = 1 from idle at floor 0.
  - Required: `motor_up` high for 3×(4+1) cycles minus CHECKs; `current_floor` steps 1, 2, 3.
  - Required: at floor 3, `inactivate_in[3]` pulses 1 cycle and `door_open` is high 3 cycles. The bench releases `active_in[3]` one cycle after the pulse; the car then returns to IDLE.
- **Collective order**
  - Stimulus: car at 0, calls `up[2]`, `down[5]`, `in[6]`.
  - Required: stops at 2 (clears up[2]), then 6 (clears in[6]), then 5 (clears down[5]). `dir_up` flips to 0 at floor 6.
- **Reversal at a turning floor**
  - Stimulus: car at 0, only `down[4]` active.
  - Required: car passes 1–3 without stopping and stops at 4. `inactivate_out_down[4]` pulses; `dir_up` = 0.
- **Door reopen**
  - Stimulus: during door counter ≥ 2 at floor 3, assert `active_in[3]`.
  - Required: `inactivate_in[3]` pulses; door stays open 3 further cycles.
- **Ends**
  - Stimulus: call `in[7]`, then `in[0]`.
  - Required: `current_floor` never exceeds 7 or underflows 0; `motor_up`/`motor_down` are never high together.

Source files
------------

// File: rtl/elevator_scheduler.sv
// Collective up/down elevator scheduler: serves latched cabin and hall calls,
// moves the car one floor at a time and returns clear pulses for served calls.
module elevator_scheduler #(
  parameter int FLOORS        = 8,
  parameter int TRAVEL_CYCLES = 100,
  parameter int DOOR_CYCLES   = 50
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [FLOORS-1:0]         active_in_levels,
  input  logic [FLOORS-2:0]         active_out_up_levels,
  input  logic [FLOORS-1:1]         active_out_down_levels,
  output logic [FLOORS-1:0]         inactivate_in_levels,
  output logic [FLOORS-2:0]         inactivate_out_up_levels,
  output logic [FLOORS-1:1]         inactivate_out_down_levels,
  output logic [$clog2(FLOORS)-1:0] current_floor,
  output logic                      motor_up,
  output logic                      motor_down,
  output logic                      door_open,
  output logic                      dir_up
);

  localparam int FW   = $clog2(FLOORS);
  localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);
  localparam logic [CW-1:0] REOPEN_MIN  = CW'(2);
  localparam logic [FW-1:0] TOP         = FW'(FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE, CHECK, DOOR} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     count, count_nx;
  logic [FW-1:0]     cur_nx;
  logic              dir_nx;
  logic [FLOORS-1:0] up_full, down_full, calls;
  logic              above, below, here, in_here, up_here, down_here;
  logic              nd, neither, stop, enter_door;
  logic              set_in, set_up, set_down;
  logic [FLOORS-1:0] inact_in_nx;
  logic [FLOORS-2:0] inact_up_nx;
  logic [FLOORS-1:1] inact_down_nx;

  // Hall vectors widened to full floor range; missing end bits read as zero.
  assign up_full   = {1'b0, active_out_up_levels};
  assign down_full = {active_out_down_levels, 1'b0};
  assign calls     = active_in_levels | up_full | down_full;

  always_comb begin
    above     = 1'b0;
    below     = 1'b0;
    in_here   = 1'b0;
    up_here   = 1'b0;
    down_here = 1'b0;
    for (int f = 0; f < FLOORS; f++) begin
      if (FW'(f) > current_floor) above = above | calls[f];
      if (FW'(f) < current_floor) below = below | calls[f];
      if (FW'(f) == current_floor) begin
        in_here   = active_in_levels[f];
        up_here   = up_full[f];
        down_here = down_full[f];
      end
    end
    here    = in_here | up_here | down_here;
    neither = !above && !below;
    // Direction the car will leave in after serving this floor.
    if (dir_up) nd = above || !(below || down_here);
    else        nd = !below && (above || up_here);
  end

  always_comb begin
    state_nx   = state;
    count_nx   = count;
    cur_nx     = current_floor;
    dir_nx     = dir_up;
    set_in     = 1'b0;
    set_up     = 1'b0;
    set_down   = 1'b0;
    enter_door = 1'b0;
    stop       = 1'b0;
    case (state)
      IDLE: begin
        if (here) begin
          enter_door = 1'b1;
        end else if (dir_up && above) begin
          dir_nx   = 1'b1;
          state_nx = MOVE;
        end else if (below) begin
          dir_nx   = 1'b0;
          state_nx = MOVE;
        end else if (above) begin
          dir_nx   = 1'b1;
          state_nx = MOVE;
        end
      end
      MOVE: begin
        if (count == TRAVEL_LAST) begin
          count_nx = '0;
          state_nx = CHECK;
          if (dir_up && current_floor != TOP)        cur_nx = current_floor + 1'b1;
          else if (!dir_up && current_floor != '0)   cur_nx = current_floor - 1'b1;
        end else begin
          count_nx = count + 1'b1;
        end
      end
      CHECK: begin
        if (current_floor == '0 || current_floor == TOP) begin
          if (here) enter_door = 1'b1;
          else      state_nx   = IDLE;
        end else begin
          if (dir_up) stop = in_here || up_here || (down_here && !above);
          else        stop = in_here || down_here || (up_here && !below);
          if (stop) enter_door = 1'b1;
          else      state_nx   = MOVE;
        end
      end
      DOOR: begin
        // First two counts are ignored while buttons_res is still clearing.
        if (count >= REOPEN_MIN && (in_here || (dir_up ? up_here : down_here))) begin
          count_nx = '0;
          set_in   = in_here;
          set_up   = dir_up && up_here;
          set_down = !dir_up && down_here;
        end else if (count == DOOR_LAST) begin
          count_nx = '0;
          state_nx = IDLE;
        end else begin
          count_nx = count + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (enter_door) begin
      state_nx = DOOR;
      count_nx = '0;
      dir_nx   = nd;
      set_in   = 1'b1;
      set_up   = nd || neither;
      set_down = !nd || neither;
    end
  end

  always_comb begin
    inact_in_nx   = '0;
    inact_up_nx   = '0;
    inact_down_nx = '0;
    for (int f = 0; f < FLOORS; f++)
      if (current_floor == FW'(f)) inact_in_nx[f] = set_in;
    for (int f = 0; f < FLOORS - 1; f++)
      if (current_floor == FW'(f)) inact_up_nx[f] = set_up;
    for (int f = 1; f < FLOORS; f++)
      if (current_floor == FW'(f)) inact_down_nx[f] = set_down;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                      <= IDLE;
      count                      <= '0;
      current_floor              <= '0;
      dir_up                     <= 1'b1;
      motor_up                   <= 1'b0;
      motor_down                 <= 1'b0;
      door_open                  <= 1'b0;
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;
    end else begin
      state                      <= state_nx;
      count                      <= count_nx;
      current_floor              <= cur_nx;
      dir_up                     <= dir_nx;
      motor_up                   <= (state_nx == MOVE) && dir_nx;
      motor_down                 <= (state_nx == MOVE) && !dir_nx;
      door_open                  <= (state_nx == DOOR);
      inactivate_in_levels       <= inact_in_nx;
      inactivate_out_up_levels   <= inact_up_nx;
      inactivate_out_down_levels <= inact_down_nx;
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: a buttons_res stand-in latches calls, and the
// expected clear pulses are queued per scenario and matched as they appear.
`timescale 1ns/1ps
module tb_elevator_scheduler;

  localparam int FLOORS = 8;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  typedef struct {
    logic [7:0] in_p;
    logic [7:0] up_p;
    logic [7:0] dn_p;
    logic [2:0] floor;
    logic       dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lat_in, set_in;
  logic [6:0] lat_up, set_up;
  logic [7:1] lat_dn, set_dn;
  logic [7:0] inact_in;
  logic [6:0] inact_up;
  logic [7:1] inact_dn;
  logic [2:0] current_floor;
  logic       motor_up, motor_down, door_open, dir_up;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb[$];
  exp_t e;

  int          w_cycles, w_mup, w_mdn, d_len;
  logic        w_got, w_both, w_door;
  logic [31:0] w_trace;
  logic [7:0]  o_in, o_up, o_dn;
  logic [2:0]  o_floor;
  logic        o_dir, o_door;

  elevator_scheduler #(
    .FLOORS(FLOORS), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .active_in_levels(lat_in),
    .active_out_up_levels(lat_up),
    .active_out_down_levels(lat_dn),
    .inactivate_in_levels(inact_in),
    .inactivate_out_up_levels(inact_up),
    .inactivate_out_down_levels(inact_dn),
    .current_floor(current_floor),
    .motor_up(motor_up),
    .motor_down(motor_down),
    .door_open(door_open),
    .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  // Call latches: set by a one-cycle request, cleared by the DUT's pulse.
  always @(posedge clk) begin
    if (reset) begin
      lat_in <= '0;
      lat_up <= '0;
      lat_dn <= '0;
    end else begin
      lat_in <= (lat_in | set_in) & ~inact_in;
      lat_up <= (lat_up | set_up) & ~inact_up;
      lat_dn <= (lat_dn | set_dn) & ~inact_dn;
    end
  end

  task automatic press(input logic [7:0] in_m, input logic [7:0] up_m, input logic [7:0] dn_m);
    @(negedge clk);
    set_in = in_m;
    set_up = up_m[6:0];
    set_dn = dn_m[7:1];
    @(negedge clk);
    set_in = '0;
    set_up = '0;
    set_dn = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    set_in = '0;
    set_up = '0;
    set_dn = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Observes the car until the next clear pulse (or budget runs out).
  task automatic wait_pulse(input int budget);
    logic [2:0] last;
    w_got = 0; w_cycles = 0; w_mup = 0; w_mdn = 0; w_both = 0; w_door = 0; w_trace = '0;
    last = current_floor;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      w_cycles++;
      if (motor_up) w_mup++;
      if (motor_down) w_mdn++;
      if (motor_up && motor_down) w_both = 1;
      if (current_floor != last) begin
        w_trace = {w_trace[27:0], 1'b0, current_floor};
        last = current_floor;
      end
      if (inact_in != 0 || inact_up != 0 || inact_dn != 0) begin
        w_got = 1;
        o_in = inact_in; o_up = {1'b0, inact_up}; o_dn = {inact_dn, 1'b0};
        o_floor = current_floor; o_dir = dir_up; o_door = door_open;
        return;
      end
      if (door_open) w_door = 1;
    end
  endtask

  task automatic door_len();
    d_len = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!door_open) return;
      d_len++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({current_floor, motor_up, motor_down, door_open, dir_up} !== {3'd0, 4'b0001}) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got floor=%0d mu=%b md=%b door=%b dir=%b, need 0 0 0 0 1",
               current_floor, motor_up, motor_down, door_open, dir_up);
    end
    tests_run++;
    if ({inact_in, inact_up, inact_dn} !== 22'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pulses: got %h, need 0", {inact_in, inact_up, inact_dn});
    end
    reset = 1'b0;
    press(8'h20, 8'h00, 8'h00);
    for (int i = 0; i < 100 && current_floor != 3'd2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    tests_run++;
    if (motor_up !== 1'b1 || current_floor !== 3'd2) begin
      tests_failed++;
      $display("[TB] FAIL reset_premove: got motor_up=%b floor=%0d, need 1 2", motor_up, current_floor);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({current_floor, motor_up, motor_down, door_open, dir_up} !== {3'd0, 4'b0001}) begin
      tests_failed++;
      $display("[TB] FAIL reset_midmove: got floor=%0d mu=%b md=%b door=%b dir=%b, need 0 0 0 0 1",
               current_floor, motor_up, motor_down, door_open, dir_up);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++;
    if ({current_floor, motor_up, motor_down, door_open} !== {3'd0, 3'b000}) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: got floor=%0d mu=%b md=%b door=%b, need idle at 0",
               current_floor, motor_up, motor_down, door_open);
    end
  endtask

  task automatic test_single_call();
    sb.push_back('{in_p: 8'h08, up_p: 8'h08, dn_p: 8'h08, floor: 3'd3, dir: 1'b1});
    press(8'h08, 8'h00, 8'h00);
    wait_pulse(100);
    e = sb.pop_front();
    tests_run++;
    if (!w_got || {o_in, o_up, o_dn} !== {e.in_p, e.up_p, e.dn_p}) begin
      tests_failed++;
      $display("[TB] FAIL single_pulse: got seen=%b in=%b up=%b dn=%b, need in=%b up=%b dn=%b",
               w_got, o_in, o_up, o_dn, e.in_p, e.up_p, e.dn_p);
    end
    tests_run++;
    if ({o_floor, o_dir, o_door} !== {e.floor, e.dir, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL single_where: got floor=%0d dir=%b door=%b, need %0d %b 1",
               o_floor, o_dir, o_door, e.floor, e.dir);
    end
    tests_run++;
    if (w_cycles != 16 || w_mup != 12 || w_mdn != 0 || w_trace !== 32'h123 || w_door !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_travel: got cycles=%0d up=%0d down=%0d path=%h door=%b, need 16 12 0 123 0",
               w_cycles, w_mup, w_mdn, w_trace, w_door);
    end
    door_len();
    tests_run++;
    if (d_len != 3) begin
      tests_failed++;
      $display("[TB] FAIL single_door: got %0d open cycles, need 3", d_len);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if ({current_floor, motor_up, motor_down, door_open} !== {3'd3, 3'b000}) begin
      tests_failed++;
      $display("[TB] FAIL single_idle: got floor=%0d mu=%b md=%b door=%b, need idle at 3",
               current_floor, motor_up, motor_down, door_open);
    end
  endtask

  task automatic test_door_reopen();
    sb.push_back('{in_p: 8'h08, up_p: 8'h08, dn_p: 8'h08, floor: 3'd3, dir: 1'b1});
    press(8'h08, 8'h00, 8'h00);
    wait_pulse(20);
    e = sb.pop_front();
    tests_run++;
    if (!w_got || w_cycles != 1 || {o_in, o_up, o_dn} !== {e.in_p, e.up_p, e.dn_p}) begin
      tests_failed++;
      $display("[TB] FAIL reopen_first: got seen=%b cycles=%0d in=%b up=%b dn=%b, need 1 1 in=%b up=%b dn=%b",
               w_got, w_cycles, o_in, o_up, o_dn, e.in_p, e.up_p, e.dn_p);
    end
    sb.push_back('{in_p: 8'h08, up_p: 8'h00, dn_p: 8'h00, floor: 3'd3, dir: 1'b1});
    press(8'h08, 8'h00, 8'h00);
    tests_run++;
    if (door_open !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reopen_held: got door_open=%b, need 1", door_open);
    end
    wait_pulse(20);
    e = sb.pop_front();
    tests_run++;
    if (!w_got || w_cycles != 1 || {o_in, o_up, o_dn} !== {e.in_p, e.up_p, e.dn_p}) begin
      tests_failed++;
      $display("[TB] FAIL reopen_pulse: got seen=%b cycles=%0d in=%b up=%b dn=%b, need 1 1 in=%b up=%b dn=%b",
               w_got, w_cycles, o_in, o_up, o_dn, e.in_p, e.up_p, e.dn_p);
    end
    door_len();
    tests_run++;
    if (d_len != 3 || o_door !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reopen_door: got %0d open cycles (door=%b), need 3", d_len, o_door);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_collective();
    do_reset();
    sb.push_back('{in_p: 8'h04, up_p: 8'h04, dn_p: 8'h00, floor: 3'd2, dir: 1'b1});
    sb.push_back('{in_p: 8'h40, up_p: 8'h00, dn_p: 8'h40, floor: 3'd6, dir: 1'b0});
    sb.push_back('{in_p: 8'h20, up_p: 8'h20, dn_p: 8'h20, floor: 3'd5, dir: 1'b0});
    press(8'h40, 8'h04, 8'h20);
    while (sb.size() > 0) begin
      wait_pulse(200);
      e = sb.pop_front();
      tests_run++;
      if (!w_got || {o_in, o_up, o_dn} !== {e.in_p, e.up_p, e.dn_p}) begin
        tests_failed++;
        $display("[TB] FAIL collective_pulse: got seen=%b in=%b up=%b dn=%b, need in=%b up=%b dn=%b",
                 w_got, o_in, o_up, o_dn, e.in_p, e.up_p, e.dn_p);
      end
      tests_run++;
      if ({o_floor, o_dir, w_both} !== {e.floor, e.dir, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL collective_where: got floor=%0d dir=%b both=%b, need %0d %b 0",
                 o_floor, o_dir, w_both, e.floor, e.dir);
      end
    end
    door_len();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reversal();
    do_reset();
    sb.push_back('{in_p: 8'h10, up_p: 8'h10, dn_p: 8'h10, floor: 3'd4, dir: 1'b0});
    press(8'h00, 8'h00, 8'h10);
    wait_pulse(100);
    e = sb.pop_front();
    tests_run++;
    if (!w_got || {o_in, o_up, o_dn} !== {e.in_p, e.up_p, e.dn_p}) begin
      tests_failed++;
      $display("[TB] FAIL reversal_pulse: got seen=%b in=%b up=%b dn=%b, need in=%b up=%b dn=%b",
               w_got, o_in, o_up, o_dn, e.in_p, e.up_p, e.dn_p);
    end
    tests_run++;
    if ({o_floor, o_dir} !== {e.floor, e.dir} || w_cycles != 21 || w_trace !== 32'h1234 || w_door !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reversal_path: got floor=%0d dir=%b cycles=%0d path=%h door=%b, need 4 0 21 1234 0",
               o_floor, o_dir, w_cycles, w_trace, w_door);
    end
    door_len();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ends();
    sb.push_back('{in_p: 8'h80, up_p: 8'h00, dn_p: 8'h80, floor: 3'd7, dir: 1'b1});
    press(8'h80, 8'h00, 8'h00);
    wait_pulse(100);
    e = sb.pop_front();
    tests_run++;
    if (!w_got || {o_in, o_up, o_dn, o_floor, o_dir} !== {e.in_p, e.up_p, e.dn_p, e.floor, e.dir}) begin
      tests_failed++;
      $display("[TB] FAIL ends_top: got seen=%b in=%b up=%b dn=%b floor=%0d dir=%b, need in=%b up=%b dn=%b %0d %b",
               w_got, o_in, o_up, o_dn, o_floor, o_dir, e.in_p, e.up_p, e.dn_p, e.floor, e.dir);
    end
    tests_run++;
    if (w_trace !== 32'h567 || w_both !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ends_top_path: got path=%h both=%b, need 567 0", w_trace, w_both);
    end
    door_len();
    repeat (2) @(negedge clk);
    sb.push_back('{in_p: 8'h01, up_p: 8'h01, dn_p: 8'h00, floor: 3'd0, dir: 1'b0});
    press(8'h01, 8'h00, 8'h00);
    wait_pulse(200);
    e = sb.pop_front();
    tests_run++;
    if (!w_got || {o_in, o_up, o_dn, o_floor, o_dir} !== {e.in_p, e.up_p, e.dn_p, e.floor, e.dir}) begin
      tests_failed++;
      $display("[TB] FAIL ends_bottom: got seen=%b in=%b up=%b dn=%b floor=%0d dir=%b, need in=%b up=%b dn=%b %0d %b",
               w_got, o_in, o_up, o_dn, o_floor, o_dir, e.in_p, e.up_p, e.dn_p, e.floor, e.dir);
    end
    tests_run++;
    if (w_trace !== 32'h6543210 || w_both !== 1'b0 || w_mdn != 28 || w_mup != 0 || w_cycles != 36) begin
      tests_failed++;
      $display("[TB] FAIL ends_bottom_path: got path=%h both=%b down=%0d up=%0d cycles=%0d, need 6543210 0 28 0 36",
               w_trace, w_both, w_mdn, w_mup, w_cycles);
    end
    door_len();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    set_in = '0;
    set_up = '0;
    set_dn = '0;
    test_reset();
    test_single_call();
    test_door_reopen();
    test_collective();
    test_reversal();
    test_ends();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
